// File: rtl/lc3_fetch_ctrl.sv
// lc3_fetch_ctrl: instruction fetch sequencer for the LC-3 datapath.
// Issues one memory read at a time from the current PC, captures the returned
// word into the instruction register, requests the PC increment, and holds
// the instruction until decode accepts it. A redirect (flush) discards the
// in-flight or held instruction; a read stalled for TIMEOUT cycles is
// abandoned and latches a sticky fault that blocks further fetches until reset.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   pc             current program counter from the PC register stage
//   run            permits starting new fetches
//   flush          redirect: cancel / discard in-flight or held instruction
//   mem_rdata      memory read data, valid with mem_ready
//   mem_ready      memory read completion
//   ir_ready       decode accepts the held instruction
//   mem_addr       fetch address
//   mem_rd         read strobe
//   ld_pc_inc      one-cycle PC increment request (ld_pc=1, pc_sel=2'b00)
//   ir, ir_pc      fetched instruction and the address it came from
//   ir_valid       ir holds an instruction not yet accepted by decode
//   mem_timeout    sticky read-timeout fault
module lc3_fetch_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc,
  input  logic        run,
  input  logic        flush,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        ir_ready,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        ld_pc_inc,
  output logic [15:0] ir,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  output logic        mem_timeout
);

  localparam int unsigned AW = 16;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] WAIT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   ir_q, ir_d;
  logic [AW-1:0]   ir_pc_q, ir_pc_d;
  logic            ir_valid_q, ir_valid_d;
  logic            timeout_q, timeout_d;
  logic            discard_q, discard_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            start;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
      discard_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      timeout_q  <= timeout_d;
      discard_q  <= discard_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state, datapath updates and strobes
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    timeout_d  = timeout_q;
    discard_d  = discard_q;
    wait_cnt_d = wait_cnt_q;
    mem_rd     = 1'b0;
    ld_pc_inc  = 1'b0;
    start      = 1'b0;

    case (state_q)
      IDLE: begin
        if (run && !flush && !timeout_q) start = 1'b1;
      end

      REQ: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          // A flush seen at any point of the read turns its data into a discard
          if (!flush && !discard_q) begin
            ld_pc_inc  = 1'b1;
            ir_d       = mem_rdata;
            ir_pc_d    = addr_q;
            ir_valid_d = 1'b1;
            state_d    = HOLD;
          end else begin
            state_d = IDLE;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          // The read stays outstanding through a flush; only its data is dropped
          wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + CW'(1);
          if (flush) discard_d = 1'b1;
        end
      end

      HOLD: begin
        if (flush) begin
          ir_valid_d = 1'b0;
          state_d    = IDLE;
        end else if (ir_ready) begin
          ir_valid_d = 1'b0;
          // pc was incremented at completion, so this chains to the next word
          if (run) start = 1'b1;
          else     state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d    = REQ;
      addr_d     = pc;
      wait_cnt_d = '0;
      discard_d  = 1'b0;
    end
  end

  assign mem_addr    = addr_q;
  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_lc3_fetch_ctrl.sv
// Bench for lc3_fetch_ctrl: directed scenarios followed by randomized traffic,
// all checked every cycle against a transaction-level fetch model.
module tb_lc3_fetch_ctrl;

  localparam int unsigned TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc;
  logic        run, flush, mem_ready, ir_ready;
  logic [15:0] mem_rdata;
  logic [15:0] mem_addr, ir, ir_pc;
  logic        mem_rd, ld_pc_inc, ir_valid, mem_timeout;

  lc3_fetch_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc         (pc),
    .run        (run),
    .flush      (flush),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .ir_ready   (ir_ready),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .ld_pc_inc  (ld_pc_inc),
    .ir         (ir),
    .ir_pc      (ir_pc),
    .ir_valid   (ir_valid),
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: a read is outstanding (busy) or an instruction is held, never both
  bit          m_busy, m_held, m_fault, m_cancel;
  int          m_waits;
  logic [15:0] m_addr, m_ir, m_irpc;
  bit          inc_pend;

  // Observations from the most recent cycle, plus running tallies
  logic [15:0] o_addr, o_ir, o_irpc;
  logic        o_rd, o_valid, o_to;
  int          n_inc, n_acc;
  logic [15:0] addr_log[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_held = 0; m_fault = 0; m_cancel = 0; m_waits = 0;
    m_addr = '0; m_ir = '0; m_irpc = '0;
  endtask

  task automatic model_start();
    m_busy = 1; m_addr = pc; m_waits = 0; m_cancel = 0;
  endtask

  // One clock edge of fetch behaviour, given the inputs present at that edge
  task automatic model_step(input logic r, input logic f, input logic rdy,
                            input logic irr, input logic [15:0] rd);
    if (m_busy) begin
      if (rdy) begin
        m_busy = 0;
        if (!f && !m_cancel) begin
          m_ir = rd; m_irpc = m_addr; m_held = 1;
        end
      end else if (m_waits == int'(TIMEOUT) - 1) begin
        m_busy = 0; m_fault = 1;
      end else begin
        m_waits = (m_waits < 15) ? m_waits + 1 : 15;
        if (f) m_cancel = 1;
      end
    end else if (m_held) begin
      if (f) m_held = 0;
      else if (irr) begin
        m_held = 0;
        if (r) model_start();
      end
    end else if (r && !f && !m_fault) begin
      model_start();
    end
  endtask

  // Drive one cycle at the falling edge, compare mid-cycle, advance model at the rising edge
  task automatic cycle(input logic r, input logic f, input logic rdy, input logic irr,
                       input logic [15:0] rd, input logic rst,
                       input logic set_pc, input logic [15:0] npc);
    logic e_inc;
    @(negedge clk);
    if (inc_pend) pc = pc + 16'd1;
    inc_pend = 0;
    if (set_pc) pc = npc;
    run = r; flush = f; mem_ready = rdy; ir_ready = irr; mem_rdata = rd; rst_n = rst;
    if (!rst) model_reset();
    #1;
    e_inc = m_busy && rdy && !f && !m_cancel;
    chk("mem_rd",      16'(mem_rd),      16'(m_busy));
    chk("mem_addr",    mem_addr,         m_addr);
    chk("ld_pc_inc",   16'(ld_pc_inc),   16'(e_inc));
    chk("ir",          ir,               m_ir);
    chk("ir_pc",       ir_pc,            m_irpc);
    chk("ir_valid",    16'(ir_valid),    16'(m_held));
    chk("mem_timeout", 16'(mem_timeout), 16'(m_fault));
    o_rd = mem_rd; o_addr = mem_addr; o_ir = ir; o_irpc = ir_pc;
    o_valid = ir_valid; o_to = mem_timeout;
    if (ld_pc_inc) n_inc++;
    if (ir_valid && irr && !f) n_acc++;
    if (mem_rd) addr_log.push_back(mem_addr);
    inc_pend = e_inc && rst;
    @(posedge clk);
    if (rst) model_step(r, f, rdy, irr, rd);
  endtask

  task automatic idle_cyc(input logic r);
    cycle(r, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
  endtask

  initial begin
    int snap_inc, n_rd, rdy_pct;
    logic r, f, rdy, irr, rst, sp;

    rst_n = 1'b0; pc = '0; run = 0; flush = 0; mem_ready = 0; ir_ready = 0; mem_rdata = '0;
    inc_pend = 0; n_inc = 0; n_acc = 0;
    model_reset();

    // Reset values
    repeat (2) cycle(0, 0, 0, 0, 16'h0, 0, 0, 16'h0);
    chk("rst_mem_addr", o_addr, 16'h0000);
    chk("rst_mem_rd",   16'(o_rd), 16'h0);
    chk("rst_ir",       o_ir, 16'h0000);
    chk("rst_ir_valid", 16'(o_valid), 16'h0);

    // Basic fetch with two wait cycles
    n_inc = 0;
    cycle(1, 0, 0, 0, 16'h0, 1, 1, 16'h3000);
    cycle(1, 0, 0, 0, 16'h0, 1, 0, 16'h0);
    chk("basic_mem_addr", o_addr, 16'h3000);
    chk("basic_mem_rd",   16'(o_rd), 16'h1);
    cycle(1, 0, 0, 0, 16'h0, 1, 0, 16'h0);
    cycle(0, 0, 1, 0, 16'h1261, 1, 0, 16'h0);
    idle_cyc(0);
    chk("basic_ir",       o_ir, 16'h1261);
    chk("basic_ir_pc",    o_irpc, 16'h3000);
    chk("basic_ir_valid", 16'(o_valid), 16'h1);
    chk("basic_inc_cnt",  16'(n_inc), 16'd1);
    cycle(0, 0, 0, 1, 16'h0, 1, 0, 16'h0);

    // Back-to-back with zero-wait memory: one accept per two cycles
    addr_log.delete(); n_acc = 0;
    cycle(1, 0, 0, 0, 16'h0, 1, 1, 16'h3000);
    repeat (6) cycle(1, 0, 1, 1, 16'h1234, 1, 0, 16'h0);
    cycle(0, 0, 1, 1, 16'h1234, 1, 0, 16'h0);
    cycle(0, 0, 1, 1, 16'h1234, 1, 0, 16'h0);
    chk("b2b_accepts", 16'(n_acc), 16'd4);
    chk("b2b_reads",   16'(addr_log.size()), 16'd4);
    if (addr_log.size() >= 3) begin
      chk("b2b_addr0", addr_log[0], 16'h3000);
      chk("b2b_addr1", addr_log[1], 16'h3001);
      chk("b2b_addr2", addr_log[2], 16'h3002);
    end

    // Flush during wait cycle 1, then data returns: discarded
    cycle(1, 0, 0, 0, 16'h0, 1, 1, 16'h3100);
    snap_inc = n_inc;
    cycle(0, 0, 0, 0, 16'h0, 1, 0, 16'h0);
    cycle(0, 1, 0, 0, 16'h0, 1, 0, 16'h0);
    cycle(0, 0, 1, 0, 16'hBEEF, 1, 0, 16'h0);
    idle_cyc(0);
    chk("flushreq_inc",      16'(n_inc - snap_inc), 16'd0);
    chk("flushreq_ir_valid", 16'(o_valid), 16'h0);
    chk("flushreq_mem_rd",   16'(o_rd), 16'h0);
    chk("flushreq_ir_kept",  o_ir, 16'h1234);

    // Flush in HOLD coinciding with ir_ready
    cycle(1, 0, 0, 0, 16'h0, 1, 1, 16'h3200);
    cycle(0, 0, 1, 0, 16'h2222, 1, 0, 16'h0);
    cycle(1, 1, 0, 1, 16'h0, 1, 0, 16'h0);
    idle_cyc(0);
    chk("flushhold_ir_valid", 16'(o_valid), 16'h0);
    chk("flushhold_mem_rd",   16'(o_rd), 16'h0);
    chk("flushhold_addr",     o_addr, 16'h3200);

    // Reset asserted mid-read, then refetch from 3000
    cycle(1, 0, 0, 0, 16'h0, 1, 1, 16'h4000);
    cycle(0, 0, 0, 0, 16'h0, 1, 0, 16'h0);
    cycle(0, 0, 0, 0, 16'h0, 0, 0, 16'h0);
    chk("rstreq_mem_rd",   16'(o_rd), 16'h0);
    chk("rstreq_mem_addr", o_addr, 16'h0000);
    chk("rstreq_ir",       o_ir, 16'h0000);
    chk("rstreq_ir_valid", 16'(o_valid), 16'h0);
    cycle(1, 0, 0, 0, 16'h0, 1, 1, 16'h3000);
    idle_cyc(0);
    chk("refetch_addr",   o_addr, 16'h3000);
    chk("refetch_mem_rd", 16'(o_rd), 16'h1);
    cycle(0, 0, 1, 0, 16'h0F0F, 1, 0, 16'h0);
    cycle(0, 0, 0, 1, 16'h0, 1, 0, 16'h0);

    // Timeout: memory never answers
    cycle(1, 0, 0, 0, 16'h0, 1, 1, 16'h3300);
    n_rd = 0;
    for (int i = 0; i < 40; i++) begin
      idle_cyc(1);
      if (o_rd) n_rd++;
    end
    chk("timeout_rd_cycles", 16'(n_rd), 16'(TIMEOUT));
    chk("timeout_flag",      16'(o_to), 16'h1);
    cycle(0, 0, 0, 0, 16'h0, 0, 0, 16'h0);
    chk("timeout_cleared",   16'(o_to), 16'h0);

    // Randomized traffic
    rdy_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        case ($urandom_range(0, 2))
          0:       rdy_pct = 20;
          1:       rdy_pct = 60;
          default: rdy_pct = 95;
        endcase
      end
      rst = ($urandom_range(0, 199) != 0);
      r   = ($urandom_range(0, 9) < 8);
      f   = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 99) < rdy_pct);
      irr = 1'($urandom_range(0, 1));
      sp  = f && ($urandom_range(0, 1) == 1);
      cycle(r, f, rdy, irr, 16'($urandom), rst, sp, 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
